uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Buffered 8N1 UART transmitter that serializes bytes onto `FPGA_SERIAL_TX`. It is the transmit end of the CPU's serial link and is clocked by `cpu_clk`. A small FIFO absorbs CPU writes, so software can queue several bytes without polling between them. Frames are sent back-to-back, LSB first, with an optional even-parity bit.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz
- `BAUD_RATE`, 115_200, line rate in bit/s
- `FIFO_DEPTH`, 4, byte slots in the input FIFO; power of two, ≥2

Ports:
- `clk` input 1, CPU clock; all state updates on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `data_in` input 8, byte to transmit
- `data_in_valid` input 1, `data_in` is presented
- `data_in_ready` output 1, FIFO can accept; byte accepted on an edge where valid & ready
- `serial_out` output 1, UART line; idle high; registered
- `busy` output 1, high while the FIFO is non-empty or a frame is in flight
- `fifo_count` output clog2(FIFO_DEPTH)+1, bytes currently queued (excludes the byte in the shifter)

## Operation
- `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer truncation). Example: 50 MHz / 115200 = 434 cycles per bit.
- Bit-period counter: width clog2(SYMBOL_EDGE_TIME). Counts 0..SYMBOL_EDGE_TIME-1, then wraps and advances the bit.
- FIFO:
  - `data_in_ready = rst_n & (fifo_count != FIFO_DEPTH)`; it is computed from registered count.
  - Push and pop on the same edge are allowed when not full; the count is unchanged.
  - When full, `data_in_ready` stays 0 for that cycle even if a pop occurs on the same edge.
- FSM states: IDLE, START, DATA, PARITY (compiled only with macro), STOP.
  - IDLE: `serial_out`=1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: drive 0 for one bit period, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` each bit period, shifting right. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: drive the XOR of the 8 data bits (even parity) for one bit period, then go to STOP.
  - STOP: drive 1 for one bit period. At its end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length: 10 bit periods (11 with parity).
- `busy = (state != IDLE) | (fifo_count != 0)`.
- `data_in` is sampled only on the accepting edge; later changes do not affect a queued byte.

## Timing
- Reset values (asserted asynchronously):
  - `serial_out`=1, `busy`=0, `fifo_count`=0, FSM=IDLE, counters=0, FIFO pointers=0.
  - `data_in_ready`=0 while `rst_n` is low, and 1 from the first cycle after release.
- Latency: a byte accepted at edge N into an empty FIFO with FSM in IDLE:
  - It is popped at edge N+1.
  - `serial_out` falls at edge N+1.
  - The start bit lasts exactly SYMBOL_EDGE_TIME cycles.
- Each bit is held exactly SYMBOL_EDGE_TIME cycles. The stop-to-start transition for queued bytes has zero extra cycles.
- Reset mid-frame:
  - `serial_out` returns to 1 immediately and the partial frame is abandoned.
  - The FIFO is flushed; bytes queued before reset are never sent.
- `data_in_valid` with ready low has no effect. The source must hold the byte; there is no drop or overwrite.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8E1 (11 bit periods).
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent and frames are 8N1 (10 bit periods).

## Test plan
- Single byte: 50 MHz / 115200; push 0xA5 at edge N.
  - `serial_out` low from N+1 for 434 cycles.
  - Data bits 1,0,1,0,0,1,0,1 at 434 cycles each, then stop 1.
  - `busy` falls after 4340 cycles.
  - With the macro: parity bit 0 precedes stop, and `busy` falls after 4774 cycles.
- Back-to-back, FIFO_DEPTH=4: push 6 bytes on consecutive cycles.
  - Byte 0 is popped immediately and bytes 1–4 fill the FIFO.
  - `data_in_ready`=0 before the 6th byte; the 6th is accepted the cycle after frame 0's stop ends.
  - Result: six contiguous frames with no idle high gap between stop and start.
- Backpressure hold: keep valid high with changing `data_in` while ready=0.
  - Only bytes on accepting edges are transmitted, in order, with no duplicates.
- Reset mid-frame: with CLOCK_FREQ=8, BAUD_RATE=1, assert `rst_n`=0 during data bit 3 with 2 bytes queued.
  - `serial_out`=1, `fifo_count`=0 and `busy`=0 immediately.
  - After release, line stays high for 100 cycles with no stray frame.
- Push while popping (CLOCK_FREQ=8, BAUD_RATE=1): with 1 byte queued, push a new byte on the same edge STOP pops.
  - `fifo_count` stays 1 and both bytes are sent in order.

Source files
------------

// File: rtl/uart_transmitter.sv
// Buffered serial transmitter: a small byte FIFO feeding an 8N1/8E1 shifter.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   data_in       - byte to queue; taken on an edge with valid & ready
//   data_in_valid - data_in is presented
//   data_in_ready - FIFO has room (low while in reset)
//   serial_out    - registered UART line, idle high
//   busy          - FIFO non-empty or a frame in flight
//   fifo_count    - bytes waiting in the FIFO (not counting the shifter)
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = (SYMBOL_EDGE_TIME > 1) ?
                        $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_MAX = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [7:0]      shift_nx;
    logic            serial_nx;
    logic            bit_end;
    logic            pop;
    logic            push;
    logic            fifo_empty;
    logic [7:0]      head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic            par_q;
`endif

    // ---------------- FIFO ----------------

    // Ready comes from the registered count only, so a pop on the
    // same edge never opens a slot for a push while full.
    assign data_in_ready = rst_n & (fifo_count != FULL);
    assign push          = data_in_valid & data_in_ready;
    assign fifo_empty    = (fifo_count == '0);
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- bit timing ----------------

    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_IDLE || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (state != S_DATA) begin
            bit_idx <= '0;
        end else if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // ---------------- FSM: state register ----------------

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = S_START;
                    pop      = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Queued bytes chain straight into the next start bit.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        state_nx = S_START;
                        pop      = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------

    // The line is registered from the next state so that it changes on
    // the same edge as the state it belongs to.
    always_comb begin
        shift_nx  = shift;
        serial_nx = 1'b1;
        if (pop) begin
            shift_nx = head;
        end else if (state == S_DATA && bit_end) begin
            shift_nx = {1'b0, shift[7:1]};
        end
        unique case (state_nx)
            S_START:  serial_nx = 1'b0;
            S_DATA:   serial_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_nx = par_q;
`endif
            default:  serial_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            serial_out <= 1'b1;
        end else begin
            shift      <= shift_nx;
            serial_out <= serial_nx;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is latched at pop because the shifter is consumed by then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (pop) begin
            par_q <= ^head;
        end
    end
`endif

    assign busy = (state != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a byte scoreboard and a
// line monitor that checks every cycle of every frame.
module tb_uart_transmitter;

    localparam int CF    = 8;
    localparam int BR    = 1;
    localparam int DEPTH = 4;
    localparam int SET   = CF / BR;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int FS = FRAME * SET;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_frames = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    uart_transmitter #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Line monitor: pops the scoreboard on each start bit and checks
    // every cycle of the frame against the expected bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && serial_out === 1'b0) begin
                logic [7:0]  b;
                logic [10:0] bits;
                logic        ab;
                logic        ok;
                logic        bad;
                start_q.push_back(cyc);
                n_frames++;
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                b = 8'h00;
                if (exp_q.size() != 0) b = exp_q.pop_front();
                bits = '1;
                bits[0] = 1'b0;
                bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
                bits[9] = ^b;
`endif
                ab = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    ok = 1'b1;
                    bad = bits[i];
                    for (int k = 0; k < SET; k++) begin
                        if (i != 0 || k != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            ab = 1'b1;
                            break;
                        end
                        if (ok && serial_out !== bits[i]) begin
                            ok = 1'b0;
                            bad = serial_out;
                        end
                    end
                    if (ab) break;
                    check($sformatf("frame_bit%0d", i), 32'(bad),
                          32'(bits[i]));
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        data_in_valid = 1'b1;
        while (data_in_ready !== 1'b1 && n < 2000) begin
            data_in = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("push_wait", 32'(n < 2000), 32'd1);
        data_in = b;
        exp_q.push_back(b);
        acc = cyc + 1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        data_in_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (n_frames < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_frames", 32'(n_frames >= target), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int acc;
        int accs[8];
        int f0;
        int s;
        logic hi_ok;
        logic [7:0] bb [8];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(data_in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(data_in_ready), 32'd1);
        check("idle_line", 32'(serial_out), 32'd1);

        // Single byte: latency, frame, busy fall
        f0 = n_frames;
        push(8'hA5, acc);
        idle_in();
        check("single_busy", 32'(busy), 32'd1);
        check("single_count", 32'(fifo_count), 32'd1);
        wait_frames(f0 + 1);
        s = start_q[f0];
        check("start_latency", 32'(s), 32'(acc + 1));
        while (cyc < s + FS - 1) @(negedge clk);
        check("busy_before_end", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        check("line_idle", 32'(serial_out), 32'd1);

        // Back-to-back with FIFO full and backpressure
        bb = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hF0, 8'h0F, 8'h3E, 8'hC7};
        f0 = n_frames;
        for (int i = 0; i < 8; i++) begin
            push(bb[i], accs[i]);
            if (i == 4) begin
                @(negedge clk);
                check("full_ready", 32'(data_in_ready), 32'd0);
                check("full_count", 32'(fifo_count), 32'(DEPTH));
            end
        end
        idle_in();
        wait_frames(f0 + 8);
        wait_idle();
        check("sixth_accept", 32'(accs[5]), 32'(start_q[f0] + FS + 1));
        for (int i = 1; i < 8; i++) begin
            check($sformatf("gap%0d", i),
                  32'(start_q[f0 + i] - start_q[f0 + i - 1]), 32'(FS));
        end

        // Push on the same edge STOP pops
        f0 = n_frames;
        push(8'h3C, acc);
        push(8'hC3, acc);
        idle_in();
        wait_frames(f0 + 1);
        s = start_q[f0];
        check("pp_count_before", 32'(fifo_count), 32'd1);
        while (cyc < s + FS - 1) @(negedge clk);
        data_in_valid = 1'b1;
        data_in = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        data_in_valid = 1'b0;
        check("pp_count_after", 32'(fifo_count), 32'd1);
        wait_frames(f0 + 3);
        wait_idle();
        check("pp_contig", 32'(start_q[f0 + 1] - start_q[f0]), 32'(FS));

        // Reset during data bit 3 with two bytes queued
        f0 = n_frames;
        push(8'h11, acc);
        push(8'h22, acc);
        push(8'h33, acc);
        idle_in();
        wait_frames(f0 + 1);
        s = start_q[f0];
        while (cyc < s + 4 * SET + SET / 2) @(negedge clk);
        check("mid_count", 32'(fifo_count), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_serial", 32'(serial_out), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(data_in_ready), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        f0 = n_frames;
        hi_ok = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(data_in_ready), 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (serial_out !== 1'b1) hi_ok = 1'b0;
            @(negedge clk);
        end
        check("post_rst_high", 32'(hi_ok), 32'd1);
        check("post_rst_frames", 32'(n_frames), 32'(f0));

        // Recovery after reset
        push(8'h96, acc);
        idle_in();
        wait_frames(f0 + 1);
        wait_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
